bcd_conv_ctrl: RTL

BCD_CONV_CTRL -- requirements
Module: bcd_conv_ctrl

---
 rtl/passcoder_pkg.sv | 18 +
 rtl/bcd_add3.sv | 15 +
 rtl/bcd_conv_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/passcoder_pkg.sv
// passcoder_pkg
// Shared definitions for the serial binary-to-BCD converter:
//   state_e      - converter FSM state encoding
//   DIGIT_W      - width of one BCD digit
//   ADD3_THRESH  - digit value at or above which the shift-add-3 step adds 3
package passcoder_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ADD3_THRESH = DIGIT_W'(5);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3
// Combinational shift-add-3 correction cell for one BCD digit.
// Ports:
//   i_digit  in   DIGIT_W  BCD digit before the shift
//   o_digit  out  DIGIT_W  i_digit + 3 when i_digit >= ADD3_THRESH, else i_digit
module bcd_add3
  import passcoder_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/bcd_conv_ctrl.sv
// bcd_conv_ctrl
// Serial double-dabble binary-to-BCD converter with a start/busy/done handshake.
// One bit of the operand is consumed per clock; the result appears BIN_W+1
// cycles after start is accepted and is held until the next result.
// Ports:
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      conversion request (accepted in IDLE or DONE)
//   a           in   BIN_W  binary operand, captured on accept
//   busy        out  1      high from the cycle after accept through DONE
//   done        out  1      one-cycle result-valid pulse
//   dec1..dec4  out  4      BCD result, dec1 = thousands, dec4 = units
//   ovf         out  1      operand exceeded 9999 (saturating build only)
// Configuration:
//   BCD_OVF_SAT_EN  defined   -> results above 9999 saturate to 9999 with ovf = 1
//                   undefined -> ovf = 0, result is the operand mod 10000
// DIGITS must be at least 4; dec1..dec4 are the lowest four digits.
//
// state | meaning
// IDLE  | waiting for start, busy low
// SHIFT | one add-3/shift step per cycle, BIN_W cycles
// DONE  | result registered, done pulse; start here chains the next conversion
module bcd_conv_ctrl
  import passcoder_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dec1,
  output logic [3:0]       dec2,
  output logic [3:0]       dec3,
  output logic [3:0]       dec4,
  output logic             ovf
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  // One extra 1-bit ten-thousands digit sits above the BCD digits.
  localparam int SR_W  = BIN_W + BCD_W + 1;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int RES_W = 4 * DIGIT_W;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_accept;
  logic               w_last;

  logic [SR_W-1:0]    r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   w_adj_bcd;
  logic [SR_W-1:0]    w_adj_full;
  logic [SR_W-1:0]    w_shift;

  logic               w_ovf_hit;
  logic [RES_W-1:0]   w_res;
  logic [DIGIT_W-1:0] r_dec1;
  logic [DIGIT_W-1:0] r_dec2;
  logic [DIGIT_W-1:0] r_dec3;
  logic [DIGIT_W-1:0] r_dec4;
  logic               r_ovf;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_sr[BIN_W + DIGIT_W*gi +: DIGIT_W]),
      .o_digit (w_adj_bcd[DIGIT_W*gi +: DIGIT_W])
    );
  end

  // The 1-bit top digit never reaches 5, so it passes through uncorrected.
  assign w_adj_full = {r_sr[SR_W-1], w_adj_bcd, r_sr[BIN_W-1:0]};
  assign w_shift    = w_adj_full << 1;

`ifdef BCD_OVF_SAT_EN
  assign w_ovf_hit = |w_shift[SR_W-1 : BIN_W + RES_W];
  assign w_res     = w_ovf_hit ? {4{4'd9}} : w_shift[BIN_W +: RES_W];
`else
  assign w_ovf_hit = 1'b0;
  assign w_res     = w_shift[BIN_W +: RES_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sr  <= {{(SR_W-BIN_W){1'b0}}, a};
      r_cnt <= CNT_W'(BIN_W);
    end else if (r_state == SHIFT) begin
      r_sr  <= w_shift;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Result is taken from the final shift directly, so it is valid in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec1 <= '0;
      r_dec2 <= '0;
      r_dec3 <= '0;
      r_dec4 <= '0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_dec1 <= w_res[3*DIGIT_W +: DIGIT_W];
      r_dec2 <= w_res[2*DIGIT_W +: DIGIT_W];
      r_dec3 <= w_res[1*DIGIT_W +: DIGIT_W];
      r_dec4 <= w_res[0 +: DIGIT_W];
      r_ovf  <= w_ovf_hit;
    end
  end

  assign dec1 = r_dec1;
  assign dec2 = r_dec2;
  assign dec3 = r_dec3;
  assign dec4 = r_dec4;
  assign ovf  = r_ovf;

endmodule
